// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between
// the MEM-stage (port 0) and IF-stage (port 1) requesters.
module mem_arbiter #(
   parameter int unsigned BITSIZE = 32,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic                 clk,
   input  logic                 resetn_i,
   input  logic [2*BITSIZE-1:0] CORE_addr_i,
   input  logic [2*BITSIZE-1:0] CORE_data_i,
   output logic [2*BITSIZE-1:0] CORE_data_o,
   input  logic [1:0]           CORE_read_i,
   input  logic [1:0]           CORE_write_i,
   input  logic [3:0]           CORE_write_size_i,
   output logic [1:0]           CORE_valid_o,
   output logic                 BUS_req_o,
   output logic                 BUS_we_o,
   output logic [1:0]           BUS_size_o,
   output logic [BITSIZE-1:0]   BUS_addr_o,
   output logic [BITSIZE-1:0]   BUS_wdata_o,
   input  logic [BITSIZE-1:0]   BUS_rdata_i,
   input  logic                 BUS_ack_i,
   output logic [1:0]           grant_o,
   output logic                 err_o
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

   state_e               state_q, state_d;
   logic                 win_q, win_d;
   logic                 last_q, last_d;
   logic                 we_q, we_d;
   logic                 err_q, err_d;
   logic [1:0]           size_q, size_d;
   logic [BITSIZE-1:0]   addr_q, addr_d;
   logic [BITSIZE-1:0]   wdata_q, wdata_d;
   logic [BITSIZE-1:0]   rd0_q, rd0_d;
   logic [BITSIZE-1:0]   rd1_q, rd1_d;
   logic [31:0]          cnt_q, cnt_d;

   logic [1:0]           req;
   logic                 pick;
   logic                 tout;

   assign req  = CORE_read_i | CORE_write_i;
   // On a tie the port that did not win last time gets the bus.
   assign pick = (req == 2'b11) ? ~last_q : req[1];
   assign tout = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      we_d    = we_q;
      err_d   = err_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd0_d   = rd0_q;
      rd1_d   = rd1_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               win_d   = pick;
               we_d    = CORE_write_i[pick];
               size_d  = pick ? CORE_write_size_i[3:2]
                              : CORE_write_size_i[1:0];
               addr_d  = pick ? CORE_addr_i[2*BITSIZE-1:BITSIZE]
                              : CORE_addr_i[BITSIZE-1:0];
               wdata_d = pick ? CORE_data_i[2*BITSIZE-1:BITSIZE]
                              : CORE_data_i[BITSIZE-1:0];
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (BUS_ack_i) begin
               if (!we_q) begin
                  if (win_q) rd1_d = BUS_rdata_i;
                  else       rd0_d = BUS_rdata_i;
               end
               last_d  = win_q;
               state_d = RESP;
            end else if (tout) begin
               if (!we_q) begin
                  if (win_q) rd1_d = '0;
                  else       rd0_d = '0;
               end
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RESP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         we_q    <= we_d;
         err_q   <= err_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign BUS_req_o    = (state_q == BUSY);
   assign BUS_we_o     = we_q;
   assign BUS_size_o   = size_q;
   assign BUS_addr_o   = addr_q;
   assign BUS_wdata_o  = wdata_q;
   assign grant_o      = (state_q != IDLE) ? {win_q, ~win_q} : 2'b00;
   assign CORE_valid_o = (state_q == RESP) ? {win_q, ~win_q} : 2'b00;
   assign CORE_data_o  = {rd1_q, rd0_q};
   assign err_o        = err_q;

endmodule
